responder_arbiter: RTL and testbench

- Front-end lock-out arbiter for the quiz responder.
- Conditions the contestant buttons and decides which contestant buzzed first.
- Flags early (foul) presses made before the round opens.
- Drives Timer_Start and Answer into the countdown timer downstream, and consumes that timer's TimeOver_Block flag to close the round.

---
 rtl/responder_pkg.sv | 31 +++
 rtl/responder_arbiter_if.sv | 30 +++
 rtl/key_debounce.sv | 48 ++++
 rtl/responder_arbiter.sv | 148 ++++++++++++++
 tb/tb_responder_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/responder_pkg.sv
// Shared types and constants for the quiz responder front-end.
package responder_pkg;

    typedef enum logic [1:0] {
        SETUP   = 2'd0,
        ARMED   = 2'd1,
        LOCKED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam int unsigned MAX_PLAYERS         = 8;
    localparam int unsigned ID_W                = 3;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_BEEP_CYCLES     = 12_500_000;

    // Index of the lowest set bit; lowest index wins simultaneous presses.
    function automatic logic [ID_W-1:0] lowest_index(input logic [MAX_PLAYERS-1:0] req);
        logic [ID_W-1:0] idx;
        logic            found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_PLAYERS; i++) begin
            if (req[i] && !found) begin
                idx   = ID_W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/responder_arbiter_if.sv
// Host/contestant/timer signal bundle for the responder arbiter.
interface responder_arbiter_if #(
    parameter int unsigned N_PLAYERS = 4
);
    import responder_pkg::*;

    logic                  Start;
    logic [N_PLAYERS-1:0]  Key;
    logic                  TimeOver_Block;
    logic                  Timer_Start;
    logic                  Answer;
    logic [ID_W-1:0]       Winner_ID;
    logic                  Winner_Valid;
    logic [N_PLAYERS-1:0]  Player_LED;
    logic [N_PLAYERS-1:0]  Foul_LED;
    logic                  Buzzer_Press;

    modport master (
        output Start, Key, TimeOver_Block,
        input  Timer_Start, Answer, Winner_ID, Winner_Valid,
               Player_LED, Foul_LED, Buzzer_Press
    );

    modport slave (
        input  Start, Key, TimeOver_Block,
        output Timer_Start, Answer, Winner_ID, Winner_Valid,
               Player_LED, Foul_LED, Buzzer_Press
    );

endinterface

// File: rtl/key_debounce.sv
// One contestant key: 2-flop synchroniser, stability debounce, and a
// registered one-cycle pulse on the debounced released->pressed edge.
module key_debounce
    import responder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic key_n,
    output logic press
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_n;
    logic             sync2_n;
    logic             deb_n;
    logic             deb_d_n;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            sync1_n <= 1'b1;
            sync2_n <= 1'b1;
            deb_n   <= 1'b1;
            deb_d_n <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1_n <= key_n;
            sync2_n <= sync1_n;
            deb_d_n <= deb_n;
            press   <= ~deb_n & deb_d_n;
            // Any return to the accepted level restarts the stability count.
            if (sync2_n == deb_n) begin
                cnt <= '0;
            end else if (cnt >= CNT_LAST) begin
                deb_n <= sync2_n;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/responder_arbiter.sv
// Lock-out arbiter: debounced keys, first-press winner selection, foul
// tracking and the lock-in beep, feeding the downstream countdown timer.
module responder_arbiter
    import responder_pkg::*;
#(
    parameter int unsigned N_PLAYERS       = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned BEEP_CYCLES     = DEF_BEEP_CYCLES
) (
    input  logic               CLK,
    input  logic               RSTn,
    responder_arbiter_if.slave bus
);

    localparam int unsigned       BEEP_W    = $clog2(BEEP_CYCLES + 1);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_CYCLES - 1);

    logic [N_PLAYERS-1:0] press;

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .CLK  (CLK),
            .RSTn (RSTn),
            .key_n(bus.Key[g]),
            .press(press[g])
        );
    end

    state_t               state, state_nx;
    logic                 timer_start, timer_start_nx;
    logic                 answer, answer_nx;
    logic [ID_W-1:0]      winner_id, winner_id_nx;
    logic                 winner_valid, winner_valid_nx;
    logic [N_PLAYERS-1:0] player_led, player_led_nx;
    logic [N_PLAYERS-1:0] foul_led, foul_led_nx;
    logic                 buzzer, buzzer_nx;
    logic [BEEP_W-1:0]    beep_cnt, beep_cnt_nx;

    logic [N_PLAYERS-1:0]   eligible;
    logic [MAX_PLAYERS-1:0] eligible_w;
    logic [ID_W-1:0]        win_id;

    assign eligible   = press & ~foul_led;
    assign eligible_w = MAX_PLAYERS'(eligible);
    assign win_id     = lowest_index(eligible_w);

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state        <= SETUP;
            timer_start  <= 1'b0;
            answer       <= 1'b0;
            winner_id    <= '0;
            winner_valid <= 1'b0;
            player_led   <= '0;
            foul_led     <= '0;
            buzzer       <= 1'b0;
            beep_cnt     <= '0;
        end else begin
            state        <= state_nx;
            timer_start  <= timer_start_nx;
            answer       <= answer_nx;
            winner_id    <= winner_id_nx;
            winner_valid <= winner_valid_nx;
            player_led   <= player_led_nx;
            foul_led     <= foul_led_nx;
            buzzer       <= buzzer_nx;
            beep_cnt     <= beep_cnt_nx;
        end
    end

    // Priority: Start > TimeOver_Block > press pulses.
    always_comb begin
        state_nx = state;
        unique case (state)
            SETUP:   if (!bus.Start) state_nx = ARMED;
            ARMED: begin
                if (bus.Start)               state_nx = SETUP;
                else if (bus.TimeOver_Block) state_nx = EXPIRED;
                else if (|eligible)          state_nx = LOCKED;
            end
            LOCKED: begin
                if (bus.Start)               state_nx = SETUP;
                else if (bus.TimeOver_Block) state_nx = EXPIRED;
            end
            EXPIRED: if (bus.Start) state_nx = SETUP;
            default: state_nx = SETUP;
        endcase
    end

    always_comb begin
        timer_start_nx  = timer_start;
        answer_nx       = answer;
        winner_id_nx    = winner_id;
        winner_valid_nx = winner_valid;
        player_led_nx   = player_led;
        foul_led_nx     = foul_led;
        buzzer_nx       = buzzer;
        beep_cnt_nx     = beep_cnt;

        unique case (state)
            SETUP: foul_led_nx = foul_led | press;
            ARMED: begin
                if (state_nx == LOCKED) begin
                    winner_id_nx    = win_id;
                    winner_valid_nx = 1'b1;
                    player_led_nx   = N_PLAYERS'(1) << win_id;
                    timer_start_nx  = 1'b1;
                    answer_nx       = 1'b1;
                    buzzer_nx       = 1'b1;
                    beep_cnt_nx     = '0;
                end
            end
            LOCKED: begin
                if (state_nx == EXPIRED) begin
                    answer_nx = 1'b0;
                    buzzer_nx = 1'b0;
                end else if (buzzer) begin
                    if (beep_cnt >= BEEP_LAST) buzzer_nx   = 1'b0;
                    else                       beep_cnt_nx = beep_cnt + 1'b1;
                end
            end
            default: ;
        endcase

        // Returning to setup wipes the whole round, fouls included.
        if (state != SETUP && state_nx == SETUP) begin
            timer_start_nx  = 1'b0;
            answer_nx       = 1'b0;
            winner_id_nx    = '0;
            winner_valid_nx = 1'b0;
            player_led_nx   = '0;
            foul_led_nx     = '0;
            buzzer_nx       = 1'b0;
            beep_cnt_nx     = '0;
        end
    end

    assign bus.Timer_Start  = timer_start;
    assign bus.Answer       = answer;
    assign bus.Winner_ID    = winner_id;
    assign bus.Winner_Valid = winner_valid;
    assign bus.Player_LED   = player_led;
    assign bus.Foul_LED     = foul_led;
    assign bus.Buzzer_Press = buzzer;

endmodule

// File: tb/tb_responder_arbiter.sv
// Scenario bench for responder_arbiter with short debounce/beep timing.
module tb_responder_arbiter;
    import responder_pkg::*;

    localparam int unsigned NP = 4;
    localparam int unsigned DB = 4;
    localparam int unsigned BP = 8;
    localparam int unsigned LAT = 2 + DB + 2;

    logic CLK = 1'b0;
    logic RSTn;
    always #5 CLK = ~CLK;

    responder_arbiter_if #(.N_PLAYERS(NP)) bus ();

    responder_arbiter #(
        .N_PLAYERS      (NP),
        .DEBOUNCE_CYCLES(DB),
        .BEEP_CYCLES    (BP)
    ) dut (
        .CLK (CLK),
        .RSTn(RSTn),
        .bus (bus)
    );

    typedef struct {
        logic [2:0]  id;
        logic [3:0]  led;
        int unsigned at;
    } exp_t;

    exp_t        sb[$];
    logic [3:0]  key_seq[$];
    logic        tob_seq[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned buzz_cnt;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_keys(input logic [3:0] v, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) key_seq.push_back(v);
    endtask

    task automatic restart_round();
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        step();
    endtask

    // Drives queued key/timer stimulus; each Timer_Start rise pops the scoreboard.
    task automatic run_window(input int unsigned n);
        logic prev_ts;
        exp_t e;
        prev_ts  = bus.Timer_Start;
        buzz_cnt = 0;
        for (int unsigned k = 1; k <= n; k++) begin
            bus.Key            = (key_seq.size() != 0) ? key_seq.pop_front() : 4'hF;
            bus.TimeOver_Block = (tob_seq.size() != 0) ? tob_seq.pop_front() : 1'b0;
            step();
            if (bus.Buzzer_Press) buzz_cnt++;
            if (bus.Timer_Start && !prev_ts) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_lock: Timer_Start rose at cycle %0d, required no lock", k);
                end else begin
                    e = sb.pop_front();
                    if (k !== e.at) begin
                        n_bad++;
                        $display("FAIL lock_latency: got %0d required %0d", k, e.at);
                    end
                    n_cmp++;
                    if (bus.Winner_ID !== e.id) begin
                        n_bad++;
                        $display("FAIL winner_id: got %0d required %0d", bus.Winner_ID, e.id);
                    end
                    n_cmp++;
                    if (bus.Player_LED !== e.led) begin
                        n_bad++;
                        $display("FAIL player_led: got %b required %b", bus.Player_LED, e.led);
                    end
                    n_cmp++;
                    if ({bus.Answer, bus.Winner_Valid, bus.Buzzer_Press} !== 3'b111) begin
                        n_bad++;
                        $display("FAIL lock_flags: got %b required 111",
                                 {bus.Answer, bus.Winner_Valid, bus.Buzzer_Press});
                    end
                end
            end
            prev_ts = bus.Timer_Start;
        end
        n_cmp++;
        if (sb.size() !== 0) begin
            n_bad++;
            $display("FAIL missing_lock: %0d expected lock(s) never seen, required 0", sb.size());
            sb.delete();
        end
        bus.Key            = 4'hF;
        bus.TimeOver_Block = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        logic [14:0] v;
        v = {bus.Timer_Start, bus.Answer, bus.Winner_ID, bus.Winner_Valid,
             bus.Player_LED, bus.Foul_LED, bus.Buzzer_Press};
        n_cmp++;
        if (v !== 15'd0) begin
            n_bad++;
            $display("FAIL %s: outputs got %b required all 0", name, v);
        end
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        bus.Start = 1'b1;
        bus.Key = 4'hF;
        bus.TimeOver_Block = 1'b0;
        repeat (3) step();
        check_all_zero("reset_outputs");
        RSTn = 1'b1;
        step();
        check_all_zero("setup_idle");
        bus.Start = 1'b0;
        step();
    endtask

    task automatic test_single_lock();
        push_keys(4'b1011, 20);
        sb.push_back('{id: 3'd2, led: 4'b0100, at: LAT});
        run_window(30);
        n_cmp++;
        if (buzz_cnt !== BP) begin
            n_bad++;
            $display("FAIL beep_length: got %0d required %0d", buzz_cnt, BP);
        end
        n_cmp++;
        if ({bus.Timer_Start, bus.Answer, bus.Buzzer_Press} !== 3'b110) begin
            n_bad++;
            $display("FAIL locked_hold: got %b required 110",
                     {bus.Timer_Start, bus.Answer, bus.Buzzer_Press});
        end
    endtask

    task automatic test_simultaneous();
        restart_round();
        push_keys(4'b0101, 10);
        sb.push_back('{id: 3'd1, led: 4'b0010, at: LAT});
        run_window(20);
        push_keys(4'b1110, 10);
        run_window(20);
        n_cmp++;
        if ({bus.Winner_ID, bus.Player_LED, bus.Answer} !== {3'd1, 4'b0010, 1'b1}) begin
            n_bad++;
            $display("FAIL late_press_ignored: id/led/answer got %0d/%b/%b required 1/0010/1",
                     bus.Winner_ID, bus.Player_LED, bus.Answer);
        end
    endtask

    task automatic test_foul();
        bus.Start = 1'b1;
        step();
        push_keys(4'b1110, 10);
        run_window(20);
        n_cmp++;
        if (bus.Foul_LED !== 4'b0001) begin
            n_bad++;
            $display("FAIL foul_set: got %b required 0001", bus.Foul_LED);
        end
        bus.Start = 1'b0;
        step();
        push_keys(4'b1110, 10);
        run_window(20);
        n_cmp++;
        if ({bus.Winner_Valid, bus.Foul_LED} !== {1'b0, 4'b0001}) begin
            n_bad++;
            $display("FAIL fouled_ignored: valid/foul got %b/%b required 0/0001",
                     bus.Winner_Valid, bus.Foul_LED);
        end
        push_keys(4'b1011, 10);
        sb.push_back('{id: 3'd2, led: 4'b0100, at: LAT});
        run_window(20);
    endtask

    task automatic test_bounce();
        restart_round();
        push_keys(4'b0111, 2);
        push_keys(4'b1111, 1);
        push_keys(4'b0111, 10);
        sb.push_back('{id: 3'd3, led: 4'b1000, at: 3 + LAT});
        run_window(30);
    endtask

    task automatic test_timeout_locked();
        bus.TimeOver_Block = 1'b1;
        step();
        bus.TimeOver_Block = 1'b0;
        n_cmp++;
        if ({bus.Answer, bus.Timer_Start, bus.Winner_ID, bus.Winner_Valid} !== {1'b0, 1'b1, 3'd3, 1'b1}) begin
            n_bad++;
            $display("FAIL expired_hold: ans/ts/id/valid got %b/%b/%0d/%b required 0/1/3/1",
                     bus.Answer, bus.Timer_Start, bus.Winner_ID, bus.Winner_Valid);
        end
        step();
        n_cmp++;
        if (bus.Timer_Start !== 1'b1) begin
            n_bad++;
            $display("FAIL expired_persist: Timer_Start got %b required 1", bus.Timer_Start);
        end
        bus.Start = 1'b1;
        step();
        check_all_zero("start_clears");
    endtask

    task automatic test_boundary();
        bus.Start = 1'b0;
        step();
        push_keys(4'b1110, 10);
        for (int unsigned i = 0; i < LAT - 1; i++) tob_seq.push_back(1'b0);
        tob_seq.push_back(1'b1);
        run_window(20);
        n_cmp++;
        if ({bus.Winner_Valid, bus.Answer, bus.Timer_Start} !== 3'b000) begin
            n_bad++;
            $display("FAIL timeout_beats_press: valid/ans/ts got %b required 000",
                     {bus.Winner_Valid, bus.Answer, bus.Timer_Start});
        end
        restart_round();
        push_keys(4'b1101, 10);
        sb.push_back('{id: 3'd1, led: 4'b0010, at: LAT});
        run_window(12);
        RSTn = 1'b0;
        step();
        check_all_zero("reset_mid_locked");
        RSTn = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_single_lock();
        test_simultaneous();
        test_foul();
        test_bounce();
        test_timeout_locked();
        test_boundary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
